mac_feed_ctrl: RTL

Input staging and sequencing stage directly upstream of the vectored MAC array. Holds one DEPTH x DEPTH matrix A (one FIFO per row) and one DEPTH-entry vector B. Once every FIFO is full, it clears the MAC accumulators and streams one column per cycle, so MAC row i accumulates C[i] = sum over k of A[i][k]*B[k]. It then returns to fill mode for the next batch.

---
 rtl/mac_feed_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mac_feed_ctrl.sv
// -----------------------------------------------------------------------------
// mac_feed_ctrl
//
// Input staging and sequencing stage in front of the vectored MAC array.
// It collects one DEPTH x DEPTH matrix A (one FIFO per row) and one
// DEPTH-entry vector B. When every FIFO is full it issues a one-cycle
// accumulator clear, then streams one column of A together with the matching
// B element per cycle for DEPTH cycles, so MAC row i accumulates
// C[i] = sum_k A[i][k] * B[k]. A one-cycle done pulse marks final results,
// after which the block returns to fill mode for the next batch.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   a_wr     per-row write strobe, bit i pushes into A FIFO i
//   a_din    per-row write data, row i in [i*DATA_W +: DATA_W]
//   b_wr     write strobe for the B FIFO
//   b_din    B write data
//   a_full   A FIFO i holds DEPTH entries
//   b_full   B FIFO holds DEPTH entries
//   busy     high from CLEAR through DONE
//   mac_clr  accumulator clear to all MAC rows
//   mac_en   per-row MAC enable (all bits equal)
//   a_out    current A element per row, same packing as a_din
//   b_out    current B element, broadcast to all rows
//   done     one-cycle pulse, MAC results are final
//
// All outputs are registered. a_out/b_out hold their last streamed value
// outside STREAM; downstream qualifies data with mac_en only.
// -----------------------------------------------------------------------------
module mac_feed_ctrl #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DEPTH-1:0]          a_wr,
  input  logic [DEPTH*DATA_W-1:0]   a_din,
  input  logic                      b_wr,
  input  logic [DATA_W-1:0]         b_din,
  output logic [DEPTH-1:0]          a_full,
  output logic                      b_full,
  output logic                      busy,
  output logic                      mac_clr,
  output logic [DEPTH-1:0]          mac_en,
  output logic [DEPTH*DATA_W-1:0]   a_out,
  output logic [DATA_W-1:0]         b_out,
  output logic                      done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                state_r;
  logic [PW-1:0]         k_r;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0]     a_mem_r  [DEPTH][DEPTH];
  logic [PW-1:0]         a_wptr_r [DEPTH];
  logic [PW-1:0]         a_rptr_r [DEPTH];
  logic [CW-1:0]         a_cnt_r  [DEPTH];
  logic [DATA_W-1:0]     b_mem_r  [DEPTH];
  logic [PW-1:0]         b_wptr_r;
  logic [PW-1:0]         b_rptr_r;
  logic [CW-1:0]         b_cnt_r;

  logic [DEPTH-1:0]      a_push_s;
  logic                  b_push_s;
  logic                  pop_s;
  logic                  start_s;

  // Circular pointer increment, correct for non-power-of-two DEPTH as well.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Push/pop qualification: writes only land in FILL and only into non-full
  // FIFOs; pops happen on the edges that load each streamed column.
  always_comb begin
    a_push_s = {DEPTH{1'b0}};
    b_push_s = 1'b0;
    pop_s    = 1'b0;
    start_s  = (&a_full) && b_full;
    case (state_r)
      ST_FILL: begin
        for (int i = 0; i < DEPTH; i++) begin
          a_push_s[i] = a_wr[i] && !a_full[i];
        end
        b_push_s = b_wr && !b_full;
      end
      ST_CLEAR: begin
        // Leaving CLEAR loads column 0 into the output registers.
        pop_s = 1'b1;
      end
      ST_STREAM: begin
        // The last column was already loaded on entry to k = DEPTH-1.
        if (k_r != PTR_LAST) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_DONE: begin
        pop_s = 1'b0;
      end
      default: begin
        pop_s = 1'b0;
      end
    endcase
  end

  // FIFO data storage; contents need no reset because pointers and counts do.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (a_push_s[i]) begin
        a_mem_r[i][a_wptr_r[i]] <= a_din[i*DATA_W +: DATA_W];
      end
    end
    if (b_push_s) begin
      b_mem_r[b_wptr_r] <= b_din;
    end
  end

  // FIFO pointers, counts and registered full flags. Push and pop are never
  // active together because they are qualified by disjoint states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_wptr_r[i] <= {PW{1'b0}};
        a_rptr_r[i] <= {PW{1'b0}};
        a_cnt_r[i]  <= {CW{1'b0}};
      end
      a_full   <= {DEPTH{1'b0}};
      b_wptr_r <= {PW{1'b0}};
      b_rptr_r <= {PW{1'b0}};
      b_cnt_r  <= {CW{1'b0}};
      b_full   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (a_push_s[i]) begin
          a_wptr_r[i] <= ptr_inc(a_wptr_r[i]);
          a_cnt_r[i]  <= a_cnt_r[i] + CW'(1);
          a_full[i]   <= ((a_cnt_r[i] + CW'(1)) == CNT_FULL);
        end else if (pop_s) begin
          a_rptr_r[i] <= ptr_inc(a_rptr_r[i]);
          a_cnt_r[i]  <= a_cnt_r[i] - CW'(1);
          a_full[i]   <= 1'b0;
        end
      end
      if (b_push_s) begin
        b_wptr_r <= ptr_inc(b_wptr_r);
        b_cnt_r  <= b_cnt_r + CW'(1);
        b_full   <= ((b_cnt_r + CW'(1)) == CNT_FULL);
      end else if (pop_s) begin
        b_rptr_r <= ptr_inc(b_rptr_r);
        b_cnt_r  <= b_cnt_r - CW'(1);
        b_full   <= 1'b0;
      end
    end
  end

  // Sequencer FSM with registered outputs: FILL -> CLEAR -> STREAM x DEPTH
  // -> DONE -> FILL. Output registers are loaded on the edge entering the
  // cycle in which they are valid, so data and mac_en stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FILL;
      k_r     <= {PW{1'b0}};
      busy    <= 1'b0;
      mac_clr <= 1'b0;
      mac_en  <= {DEPTH{1'b0}};
      a_out   <= {(DEPTH*DATA_W){1'b0}};
      b_out   <= {DATA_W{1'b0}};
      done    <= 1'b0;
    end else begin
      case (state_r)
        ST_FILL: begin
          if (start_s) begin
            state_r <= ST_CLEAR;
            busy    <= 1'b1;
            mac_clr <= 1'b1;
          end else begin
            state_r <= ST_FILL;
            busy    <= 1'b0;
            mac_clr <= 1'b0;
          end
          mac_en <= {DEPTH{1'b0}};
          done   <= 1'b0;
        end
        ST_CLEAR: begin
          state_r <= ST_STREAM;
          k_r     <= {PW{1'b0}};
          mac_clr <= 1'b0;
          mac_en  <= {DEPTH{1'b1}};
          for (int i = 0; i < DEPTH; i++) begin
            a_out[i*DATA_W +: DATA_W] <= a_mem_r[i][a_rptr_r[i]];
          end
          b_out <= b_mem_r[b_rptr_r];
        end
        ST_STREAM: begin
          if (k_r == PTR_LAST) begin
            state_r <= ST_DONE;
            mac_en  <= {DEPTH{1'b0}};
            done    <= 1'b1;
          end else begin
            state_r <= ST_STREAM;
            k_r     <= k_r + PW'(1);
            for (int i = 0; i < DEPTH; i++) begin
              a_out[i*DATA_W +: DATA_W] <= a_mem_r[i][a_rptr_r[i]];
            end
            b_out <= b_mem_r[b_rptr_r];
          end
        end
        ST_DONE: begin
          state_r <= ST_FILL;
          busy    <= 1'b0;
          done    <= 1'b0;
          mac_en  <= {DEPTH{1'b0}};
          mac_clr <= 1'b0;
        end
        default: begin
          state_r <= ST_FILL;
          k_r     <= {PW{1'b0}};
          busy    <= 1'b0;
          mac_clr <= 1'b0;
          mac_en  <= {DEPTH{1'b0}};
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
